bnn_feature_loader: RTL and testbench

// - Host-side front/back end for a sequential BNN classifier (gasId-class, romex_seq core).
// - Accepts features one FEAT_BITS word per valid/ready beat and packs them onto the classifier's

---
 rtl/bnn_feature_loader.sv | 131 +++++++++++++
 tb/tb_bnn_feature_loader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bnn_feature_loader.sv
// Streams FEAT_BITS words onto a wide feature bus, waits a fixed latency, then returns the prediction.
// Optional completed-inference counter is enabled with `define BNN_LOADER_CNT_EN.
module bnn_feature_loader #(
  parameter int FEAT_CNT     = 128,
  parameter int FEAT_BITS    = 4,
  parameter int CLASS_CNT    = 6,
  parameter int INFER_CYCLES = 48,
  localparam int PRED_W      = (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [FEAT_BITS-1:0]          in_data,
  output logic [FEAT_CNT*FEAT_BITS-1:0] features,
  input  logic [PRED_W-1:0]             prediction,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [PRED_W-1:0]             res_data,
  output logic                          busy,
  output logic [15:0]                   infer_cnt
);

  localparam int IDX_W = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
  localparam int CNT_W = $clog2(INFER_CYCLES + 1);

  typedef enum logic [1:0] {ST_LOAD, ST_WAIT, ST_OUT} state_t;

  state_t                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [FEAT_CNT*FEAT_BITS-1:0] features_q, features_d;
  logic                          in_ready_q, in_ready_d;
  logic                          res_valid_q, res_valid_d;
  logic [PRED_W-1:0]             res_data_q, res_data_d;
  logic                          beat;
  logic                          result_hs;

  assign beat      = in_valid && in_ready_q;
  assign result_hs = (state_q == ST_OUT) && res_valid_q && res_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    features_d  = features_q;
    in_ready_d  = in_ready_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    case (state_q)
      ST_LOAD: begin
        in_ready_d = 1'b1;
        if (beat) begin
          features_d[int'(idx_q)*FEAT_BITS +: FEAT_BITS] = in_data;
          if (idx_q == IDX_W'(FEAT_CNT - 1)) begin
            idx_d      = '0;
            cnt_d      = CNT_W'(INFER_CYCLES);
            in_ready_d = 1'b0;
            state_d    = ST_WAIT;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      // Capture happens one edge after the counter has drained, giving INFER_CYCLES+1 edges total.
      ST_WAIT: begin
        in_ready_d = 1'b0;
        if (cnt_q == '0) begin
          res_data_d  = prediction;
          res_valid_d = 1'b1;
          state_d     = ST_OUT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_OUT: begin
        in_ready_d = 1'b0;
        if (result_hs) begin
          res_valid_d = 1'b0;
          state_d     = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

`ifdef BNN_LOADER_CNT_EN
  logic [15:0] infer_cnt_q, infer_cnt_d;

  always_comb begin
    infer_cnt_d = infer_cnt_q;
    if (result_hs) infer_cnt_d = infer_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) infer_cnt_q <= 16'h0000;
    else      infer_cnt_q <= infer_cnt_d;
  end

  assign infer_cnt = infer_cnt_q;
`else
  assign infer_cnt = 16'h0000;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_LOAD;
      idx_q       <= '0;
      cnt_q       <= '0;
      features_q  <= '0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      features_q  <= features_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign features  = features_q;
  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign busy      = (state_q != ST_LOAD);

endmodule

// File: tb/tb_bnn_feature_loader.sv
// Directed self-checking bench for bnn_feature_loader at default parameters.
// Counter checks follow `define BNN_LOADER_CNT_EN when set for the build.
module tb_bnn_feature_loader;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_data;
  logic [511:0] features;
  logic [2:0]   prediction;
  logic         res_valid;
  logic         res_ready;
  logic [2:0]   res_data;
  logic         busy;
  logic [15:0]  infer_cnt;

  int           checks = 0;
  int           errors = 0;
  logic [15:0]  exp_cnt = 16'h0000;

`ifdef BNN_LOADER_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [511:0] VEC_RAMP = {8{64'hFEDCBA9876543210}};
  localparam logic [511:0] VEC_A    = {128{4'hA}};

  bnn_feature_loader dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .features   (features),
    .prediction (prediction),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .busy       (busy),
    .infer_cnt  (infer_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the last accepted beat.
  task automatic load_words(input bit ramp, input bit toggle, input int n, input int start);
    int beats = 0;
    int cyc   = 0;
    logic v;
    while (beats < n && cyc < 2000) begin
      v        = toggle ? (cyc % 2 == 0) : 1'b1;
      in_valid = v;
      in_data  = ramp ? 4'((start + beats) % 16) : 4'hA;
      if (v && in_ready) beats++;
      cyc++;
      @(negedge clk);
    end
    check("load_beats", 512'(beats), 512'(n));
  endtask

  task automatic wait_result(input logic [2:0] pred);
    int edges = 0;
    prediction = 3'd7;
    check("wait_in_ready", 512'(in_ready), 512'(0));
    check("wait_busy", 512'(busy), 512'(1));
    check("wait_res_valid_early", 512'(res_valid), 512'(0));
    while (!res_valid && edges < 200) begin
      @(negedge clk);
      edges++;
      if (edges == 5) prediction = pred;
    end
    check("result_latency", 512'(edges), 512'(49));
    check("result_data", 512'(res_data), 512'(pred));
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    exp_cnt   = exp_cnt + 16'd1;
    check("hs_res_valid", 512'(res_valid), 512'(0));
    check("hs_in_ready_low", 512'(in_ready), 512'(0));
    check("hs_busy", 512'(busy), 512'(0));
    check("infer_cnt", 512'(infer_cnt), CNT_EN ? 512'(exp_cnt) : 512'(0));
    @(negedge clk);
    check("hs_in_ready_high", 512'(in_ready), 512'(1));
  endtask

  initial begin
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_data    = 4'h0;
    res_ready  = 1'b0;
    prediction = 3'd0;

    #3;
    check("reset_features", features, 512'(0));
    check("reset_in_ready", 512'(in_ready), 512'(0));
    check("reset_res_valid", 512'(res_valid), 512'(0));
    check("reset_busy", 512'(busy), 512'(0));
    check("reset_infer_cnt", 512'(infer_cnt), 512'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_reset_in_ready_low", 512'(in_ready), 512'(0));
    @(negedge clk);
    check("post_reset_in_ready_high", 512'(in_ready), 512'(1));

    // T1: back-to-back ramp
    load_words(1'b1, 1'b0, 128, 0);
    in_valid = 1'b0;
    check("t1_features", features, VEC_RAMP);
    wait_result(3'd4);
    consume();

    // T2 + T3: toggling in_valid, then a stalled result
    load_words(1'b1, 1'b1, 128, 0);
    in_valid = 1'b0;
    check("t2_features", features, VEC_RAMP);
    wait_result(3'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_res_valid", 512'(res_valid), 512'(1));
      check("t3_res_data", 512'(res_data), 512'(3'd4));
      check("t3_in_ready", 512'(in_ready), 512'(0));
    end
    consume();

    // T4: reset mid-load
    load_words(1'b1, 1'b0, 50, 0);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    exp_cnt = 16'h0000;
    #1;
    check("t4_async_features", features, 512'(0));
    check("t4_async_in_ready", 512'(in_ready), 512'(0));
    check("t4_async_res_data", 512'(res_data), 512'(0));
    check("t4_async_busy", 512'(busy), 512'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t4_in_ready", 512'(in_ready), 512'(1));
    load_words(1'b0, 1'b0, 128, 0);
    check("t4_features", features, VEC_A);

    // T5: junk words offered during WAIT and OUT
    in_valid = 1'b1;
    in_data  = 4'hF;
    wait_result(3'd1);
    check("t5_features_hold_wait", features, VEC_A);
    consume();
    check("t5_features_hold_out", features, VEC_A);
    load_words(1'b1, 1'b0, 1, 0);
    check("t5_first_word", 512'(features[7:0]), 512'(8'hA0));
    load_words(1'b1, 1'b0, 127, 1);
    in_valid = 1'b0;
    check("t5_features", features, VEC_RAMP);
    wait_result(3'd5);
    consume();

    // T6: counter, including wrap when the feature is built in
    load_words(1'b1, 1'b0, 128, 0);
    in_valid = 1'b0;
    wait_result(3'd2);
    consume();
`ifdef BNN_LOADER_CNT_EN
    force dut.infer_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.infer_cnt_q;
    exp_cnt = 16'hFFFF;
`endif
    load_words(1'b0, 1'b0, 128, 0);
    in_valid = 1'b0;
    wait_result(3'd3);
    consume();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
